// File: rtl/seq_gen_if.sv
// Handshake and drive lines between the unlock-sequence generator and its controller/detector.
interface seq_gen_if;
  logic start;
  logic z;
  logic P1;
  logic P2;
  logic busy;
  logic done;
  logic pass;

  modport master (
    output start,
    output z,
    input  P1,
    input  P2,
    input  busy,
    input  done,
    input  pass
  );

  modport slave (
    input  start,
    input  z,
    output P1,
    output P2,
    output busy,
    output done,
    output pass
  );
endinterface

// File: rtl/seq_gen.sv
// Unlock-sequence generator: emits P1,P1,<GAP idle>,P2,P1 then reports the detector's z response.
module seq_gen #(
  parameter int unsigned GAP = 2
) (
  input  logic     clk,
  input  logic     reset,
  seq_gen_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] GAP_LOAD = (GAP > 0) ? CNT_W'(GAP - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_A1   = 3'd1,
    S_A2   = 3'd2,
    S_WAIT = 3'd3,
    S_B    = 3'd4,
    S_CHK  = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           state;
  state_t           state_nxt_c;
  logic [CNT_W-1:0] gap_cnt;
  logic             p1_q;
  logic             p2_q;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  function automatic state_t next_state(input state_t cur, input logic start,
                                        input logic [CNT_W-1:0] cnt);
    next_state = S_IDLE;
    case (cur)
      S_IDLE:  next_state = start ? S_A1 : S_IDLE;
      S_A1:    next_state = S_A2;
      S_A2:    next_state = (GAP > 0) ? S_WAIT : S_B;
      S_WAIT:  next_state = (cnt == '0) ? S_B : S_WAIT;
      S_B:     next_state = S_CHK;
      S_CHK:   next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  endfunction

  // Moore decode {P1, P2, busy, done}; applied to the next state so outputs leave flops
  function automatic logic [3:0] decode(input state_t st);
    decode = 4'b0000;
    case (st)
      S_A1, S_A2, S_CHK: decode = 4'b1010;
      S_WAIT:            decode = 4'b0010;
      S_B:               decode = 4'b0110;
      S_DONE:            decode = 4'b0011;
      default:           decode = 4'b0000;
    endcase
  endfunction

  assign state_nxt_c = next_state(state, bus.start, gap_cnt);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      gap_cnt <= '0;
      p1_q    <= 1'b0;
      p2_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state                          <= state_nxt_c;
      {p1_q, p2_q, busy_q, done_q}   <= decode(state_nxt_c);

      if (state == S_A2) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == S_WAIT) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - CNT_W'(1);
      end

      // Result is cleared when a new request is taken and captured from z in CHK
      if ((state == S_IDLE) && bus.start) begin
        pass_q <= 1'b0;
      end else if (state == S_CHK) begin
        pass_q <= bus.z;
      end
    end
  end

  assign bus.P1   = p1_q;
  assign bus.P2   = p2_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.pass = pass_q;

endmodule

// File: tb/tb_seq_gen.sv
// Scoreboard bench for seq_gen with three instances (GAP = 2, 0, 15) on a shared clock and reset.
module tb_seq_gen;

  localparam int unsigned GAP0 = 2;
  localparam int unsigned GAP1 = 0;
  localparam int unsigned GAP2 = 15;

  typedef struct {
    int k;
    int g;
    bit pass;
  } seq_exp_t;

  typedef struct {
    int         cyc;
    int         inst;
    logic [4:0] v;
    int         tag;
  } snap_t;

  logic clk;
  logic rst;
  logic st [3];
  logic zz [3];
  logic mp1 [3];
  logic mp2 [3];
  logic mbusy [3];
  logic mdone [3];
  logic mpass [3];

  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int snap_n = 0;
  bit finish_req = 1'b0;

  seq_exp_t exp_q [3][$];
  snap_t    snap_q[$];

  seq_gen_if sif [3] ();

  for (genvar g = 0; g < 3; g++) begin : g_dut
    seq_gen #(
      .GAP((g == 0) ? GAP0 : ((g == 1) ? GAP1 : GAP2))
    ) u_dut (
      .clk  (clk),
      .reset(rst),
      .bus  (sif[g])
    );
    assign sif[g].start = st[g];
    assign sif[g].z     = zz[g];
    assign mp1[g]       = sif[g].P1;
    assign mp2[g]       = sif[g].P2;
    assign mbusy[g]     = sif[g].busy;
    assign mdone[g]     = sif[g].done;
    assign mpass[g]     = sif[g].pass;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int gap_of(input int i);
    return (i == 0) ? int'(GAP0) : ((i == 1) ? int'(GAP1) : int'(GAP2));
  endfunction

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic snap(input int c, input int i, input logic [4:0] v);
    snap_t s;
    s.cyc  = c;
    s.inst = i;
    s.v    = v;
    s.tag  = snap_n;
    snap_n++;
    snap_q.push_back(s);
  endtask

  // One start pulse; z is the inverse of zv except in the CHK cycle.
  task automatic run_seq(input int i, input bit zv);
    int k;
    int g;
    seq_exp_t e;
    g = gap_of(i);
    k = cyc;
    st[i] = 1'b1;
    zz[i] = !zv;
    e.k = k; e.g = g; e.pass = zv;
    exp_q[i].push_back(e);
    snap(k + 1, i, 5'b10100);
    snap(k + 2, i, 5'b10100);
    snap(k + 3 + g, i, 5'b01100);
    snap(k + 5 + g, i, {4'b0011, zv});
    tick();
    st[i] = 1'b0;
    while (cyc < k + 4 + g) tick();
    zz[i] = zv;
    tick();
    zz[i] = !zv;
    while (cyc < k + 6 + g) tick();
  endtask

  initial begin
    int k;
    int c0;
    seq_exp_t e;
    for (int i = 0; i < 3; i++) begin
      st[i] = 1'b0;
      zz[i] = 1'b0;
    end
    rst = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) snap(cyc + 1, i, 5'b00000);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) snap(cyc + 4, i, 5'b00000);
    repeat (5) tick();

    // GAP=2: pass retained in idle, then cleared by reset
    run_seq(0, 1'b1);
    snap(cyc + 2, 0, 5'b00001);
    repeat (3) tick();
    rst = 1'b1;
    snap(cyc + 1, 0, 5'b00000);
    tick();
    rst = 1'b0;
    tick();
    run_seq(0, 1'b1);
    run_seq(0, 1'b0);

    // GAP=2: reset in the first WAIT cycle aborts the sequence
    k = cyc;
    st[0] = 1'b1;
    zz[0] = 1'b1;
    snap(k + 3, 0, 5'b00100);
    tick();
    st[0] = 1'b0;
    while (cyc < k + 3) tick();
    rst = 1'b1;
    snap(k + 4, 0, 5'b00000);
    tick();
    rst = 1'b0;
    snap(k + 6, 0, 5'b00000);
    while (cyc < k + 7) tick();
    run_seq(0, 1'b1);

    // GAP=0
    run_seq(1, 1'b0);
    run_seq(1, 1'b1);

    // GAP=0: a second start while busy must be dropped
    k = cyc;
    st[1] = 1'b1;
    zz[1] = 1'b1;
    e.k = k; e.g = 0; e.pass = 1'b1;
    exp_q[1].push_back(e);
    tick();
    st[1] = 1'b0;
    tick();
    st[1] = 1'b1;
    tick();
    st[1] = 1'b0;
    while (cyc < k + 8) tick();
    zz[1] = 1'b0;

    // GAP=15: start held 40 cycles gives two sequences one idle cycle apart
    c0 = cyc;
    st[2] = 1'b1;
    e.k = c0; e.g = 15; e.pass = 1'b1;
    exp_q[2].push_back(e);
    e.k = c0 + 21; e.g = 15; e.pass = 1'b0;
    exp_q[2].push_back(e);
    snap(c0 + 21, 2, 5'b00001);
    snap(c0 + 22, 2, 5'b10100);
    for (int n = 0; n < 40; n++) begin
      zz[2] = (cyc == c0 + 19);
      tick();
    end
    st[2] = 1'b0;
    zz[2] = 1'b0;
    while (cyc < c0 + 46) tick();

    finish_req = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  task automatic chk(input string name, input int i, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s inst%0d cyc=%0d got %0d expected %0d", name, i, cyc, act, exp);
    end
  endtask

  int busy_first [3];
  int p1c [3][3];
  int p1n [3];
  int p2c [3];
  bit prev_busy [3];
  bit after_done [3];

  initial begin
    for (int i = 0; i < 3; i++) begin
      busy_first[i] = -1;
      p1n[i]        = 0;
      p2c[i]        = -1;
      prev_busy[i]  = 1'b0;
      after_done[i] = 1'b0;
      for (int j = 0; j < 3; j++) p1c[i][j] = -1;
    end
  end

  always @(negedge clk) begin
    seq_exp_t e;
    int have;
    for (int i = 0; i < 3; i++) begin
      if (mbusy[i] && !prev_busy[i]) begin
        busy_first[i] = cyc;
        p1n[i] = 0;
        p2c[i] = -1;
        for (int j = 0; j < 3; j++) p1c[i][j] = -1;
      end
      if (mp1[i]) begin
        if (p1n[i] < 3) p1c[i][p1n[i]] = cyc;
        p1n[i]++;
      end
      if (mp2[i]) p2c[i] = cyc;
      chk("p1_p2_overlap", i, int'(mp1[i] & mp2[i]), 0);
      if (after_done[i]) begin
        chk("busy_after_done", i, int'(mbusy[i]), 0);
        after_done[i] = 1'b0;
      end
      if (mdone[i]) begin
        have = exp_q[i].size();
        chk("done_expected", i, int'(have > 0), 1);
        if (have > 0) begin
          e = exp_q[i].pop_front();
          chk("busy_first", i, busy_first[i], e.k + 1);
          chk("busy_len", i, cyc - busy_first[i] + 1, 5 + e.g);
          chk("p1_count", i, p1n[i], 3);
          chk("p1_first", i, p1c[i][0], e.k + 1);
          chk("p1_second", i, p1c[i][1], e.k + 2);
          chk("p1_third", i, p1c[i][2], e.k + 4 + e.g);
          chk("p2_cycle", i, p2c[i], e.k + 3 + e.g);
          chk("done_cycle", i, cyc, e.k + 5 + e.g);
          chk("pass", i, int'(mpass[i]), int'(e.pass));
        end
        after_done[i] = 1'b1;
      end
      prev_busy[i] = mbusy[i];
    end

    for (int j = snap_q.size() - 1; j >= 0; j--) begin
      if (snap_q[j].cyc <= cyc) begin
        chk($sformatf("snap%0d_outs", snap_q[j].tag), snap_q[j].inst,
            int'({mp1[snap_q[j].inst], mp2[snap_q[j].inst], mbusy[snap_q[j].inst],
                  mdone[snap_q[j].inst], mpass[snap_q[j].inst]}),
            int'(snap_q[j].v));
        if (snap_q[j].cyc < cyc) chk("snap_missed", snap_q[j].inst, snap_q[j].cyc, cyc);
        snap_q.delete(j);
      end
    end

    if (cyc > 5000) chk("watchdog", 0, cyc, 5000);

    if (finish_req || cyc > 5000) begin
      for (int i = 0; i < 3; i++) chk("pending_seqs", i, exp_q[i].size(), 0);
      chk("pending_snaps", 0, snap_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 Parameter: GAP, default 2, number of idle cycles (P1=P2=0) between the second P1 pulse and the P2 pulse; legal range 0..15.
REQ-002 Port: clk  input  1  single system clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  reset; synchronous, active-high.
REQ-004 Port: start  input  1  request to emit one unlock sequence; sampled on rising edge of clk.
REQ-005 Port: z  input  1  detector response (Mealy output of the downstream sequence detector); sampled only in the CHK cycle.
REQ-006 Port: P1  output  1  button-1 drive to detector; registered.
REQ-007 Port: P2  output  1  button-2 drive to detector; registered.
REQ-008 Port: busy  output  1  high while a sequence is in progress, including the DONE cycle.
REQ-009 Port: done  output  1  one-cycle pulse marking sequence completion.
REQ-010 Port: pass  output  1  result of the last completed sequence: 1 = z was high in the CHK cycle.

Function
REQ-011 The FSM SHALL have states IDLE, A1, A2, WAIT, B, CHK, DONE, encoded in 3 bits, with unused encodings returning to IDLE on the next edge.
REQ-012 Outputs SHALL be decoded from the state register only (Moore): P1=1 in A1, A2, CHK; P2=1 in B; busy=1 in every state except IDLE; done=1 in DONE only.
REQ-013 IDLE: start=1 -> A1 and pass cleared to 0 on the same edge; start=0 -> stay in IDLE.
REQ-014 A1 -> A2 unconditionally; the two P1 cycles SHALL be back-to-back with no gap.
REQ-015 A2 -> WAIT with a 4-bit gap counter loaded with GAP-1 if GAP>0; A2 -> B directly if GAP=0.
REQ-016 WAIT: counter decrements each cycle; at counter=0 -> B; WAIT SHALL last exactly GAP cycles.
REQ-017 B -> CHK unconditionally; P2 is a single-cycle pulse.
REQ-018 CHK -> DONE unconditionally; on the same edge pass SHALL load the value of z sampled at that edge.
REQ-019 DONE -> IDLE unconditionally; pass SHALL hold its value until the next accepted start or reset.
REQ-020 start SHALL be ignored in every state except IDLE; no queuing of requests.
REQ-021 Latency: start accepted at edge k -> P1 high in cycles k+1 and k+2, P2 high in cycle k+3+GAP, P1 high in cycle k+4+GAP, done high in cycle k+5+GAP; busy high for exactly 5+GAP cycles.
REQ-022 P1 and P2 SHALL never be high in the same cycle.
REQ-023 start held high continuously SHALL produce back-to-back sequences separated by exactly one IDLE cycle.
REQ-024 z SHALL have no effect on state, P1, P2, busy or done in any state.

Reset
REQ-025 reset=1 at a rising edge SHALL force state to IDLE, gap counter to 0 and pass to 0, so P1=P2=busy=done=pass=0 in the following cycle.
REQ-026 reset SHALL take priority over start and over every state transition, including mid-sequence (A1..DONE).
REQ-027 After reset is released, the block SHALL stay in IDLE until start is sampled high.

Verification
REQ-028 GAP=2, connected to the detector, start pulse at edge k -> P1 in k+1,k+2; P2 in k+5; P1 in k+6 with z=1; done in k+7 with pass=1; busy high k+1..k+7.
REQ-029 GAP=0, z tied 0 -> P2 in k+3, P1 in k+4, done in k+5 with pass=0; busy high exactly 5 cycles.
REQ-030 GAP=15, start held high for 40 cycles -> two complete sequences, each busy for 20 cycles, separated by one idle cycle; start pulses during busy have no effect.
REQ-031 reset asserted during WAIT -> next cycle all outputs 0, state IDLE; new start afterward produces a full, correctly timed sequence.
REQ-032 Pass retention: sequence with z=1 gives pass=1 held through IDLE; next accepted start clears pass to 0 on the acceptance edge; a second sequence with z=0 leaves pass=0.
